// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the instruction-fetch stage
// and the MEM stage of a 5-stage MIPS pipeline. Only one memory transaction is
// in flight at a time. Completion comes from mem_ready. If mem_ready does not
// arrive within MAX_WAIT cycles, the transaction is aborted and the sticky
// bus_err flag is set.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   if_req/if_addr                 fetch request, held until if_ack
//   if_rdata/if_ack                fetched word and one-cycle completion pulse
//   dm_readmem/dm_writemem         data strobes, held until dm_ack
//   dm_addr/dm_wdata               data address and store data
//   dm_rdata/dm_ack                load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                      memory-side request, stable until completion
//   mem_rdata/mem_ready            memory read data and completion strobe
//   stall_if/stall_mem             pipeline freeze requests (combinational)
//   bus_err                        sticky timeout flag
//
// Build option
//   MEM_ARB_RR_EN  defined: round-robin when both requesters are pending.
//                  undefined: the data port always wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_readmem,
    input  logic              dm_writemem,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    // Wait-count value on which the next unready cycle aborts.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              bus_err_q, bus_err_d;

    logic dm_pend;
    logic if_pend;
    logic pick_data;
    logic finish;

    // A requester whose ack is high this cycle is still holding its old
    // request and must not be granted again.
    assign dm_pend = (dm_readmem | dm_writemem) & ~dm_ack_q;
    assign if_pend = if_req & ~if_ack_q;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;   // 1 = data port was served last
    assign pick_data = dm_pend & (~if_pend | ~last_d_q);
`else
    assign pick_data = dm_pend;
`endif

    // Normal completion or timeout abort.
    assign finish = mem_ready | (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        bus_err_d   = bus_err_q;
`ifdef MEM_ARB_RR_EN
        last_d_d    = last_d_q;
`endif
        unique case (state_q)
            IDLE: begin
                // mem_ready is ignored here.
                if (pick_data) begin
                    state_d     = GRANT_D;
                    wait_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_writemem;   // write wins over read
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
`ifdef MEM_ARB_RR_EN
                    last_d_d    = 1'b1;
`endif
                end else if (if_pend) begin
                    state_d    = GRANT_I;
                    wait_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
`ifdef MEM_ARB_RR_EN
                    last_d_d   = 1'b0;
`endif
                end
            end
            GRANT_I, GRANT_D: begin
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!mem_ready) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == GRANT_I) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!mem_ready) begin
                            dm_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_pend;
    assign stall_mem = dm_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_readmem = 1'b0;
    logic        dm_writemem = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .dm_readmem (dm_readmem),
        .dm_writemem(dm_writemem),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .bus_err    (bus_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] wmem [logic [31:0]];
    int          delay_knob = 0;   // <0: random latency 0..4

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (wmem.exists(a)) return wmem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    // Memory responder: ready after a chosen number of wait cycles.
    initial begin : responder
        int   delay;
        logic prev_req;
        delay    = 0;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (!prev_req) delay = (delay_knob < 0) ? int'($urandom_range(0, 4)) : delay_knob;
                else if (delay > 0) delay--;
                mem_ready = (delay == 0);
                if (mem_ready && mem_we) wmem[mem_addr] = mem_wdata;
                mem_rdata = (mem_ready && !mem_we) ? memval(mem_addr) : $urandom;
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            prev_req = mem_req;
        end
    end

    // ---------------- transaction-level reference ----------------
    bit          m_busy, m_isd, m_we, m_ifack, m_dmack, m_err;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dmr;
    int          m_waits;
`ifdef MEM_ARB_RR_EN
    bit          m_lastd;
`endif

    task automatic model_reset();
        m_busy = 0; m_isd = 0; m_we = 0; m_ifack = 0; m_dmack = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0; m_waits = 0;
`ifdef MEM_ARB_RR_EN
        m_lastd = 0;
`endif
    endtask

    task automatic model_step();
        bit dpend, ipend, serve_d, ok;
        dpend   = (dm_readmem || dm_writemem) && !m_dmack;
        ipend   = if_req && !m_ifack;
        m_ifack = 0;
        m_dmack = 0;
        if (m_busy) begin
            ok = mem_ready;
            if (!ok) m_waits++;
            if (ok || m_waits == MAX_WAIT) begin
                m_busy = 0;
                if (!ok) m_err = 1;
                if (m_isd) begin
                    m_dmack = 1;
                    if (!ok) m_dmr = '0;
                    else if (!m_we) m_dmr = memval(m_addr);
                end else begin
                    m_ifack = 1;
                    m_ifr   = ok ? memval(m_addr) : '0;
                end
            end
        end else if (dpend || ipend) begin
`ifdef MEM_ARB_RR_EN
            serve_d = dpend && (!ipend || !m_lastd);
            m_lastd = serve_d;
`else
            serve_d = dpend;
`endif
            m_busy  = 1;
            m_waits = 0;
            m_isd   = serve_d;
            if (serve_d) begin
                m_we = dm_writemem; m_addr = dm_addr; m_wdata = dm_wdata;
            end else begin
                m_we = 0; m_addr = if_addr;
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            chk1 ("mem_req",   mem_req,   m_busy);
            chk1 ("mem_we",    mem_we,    m_we);
            chk32("mem_addr",  mem_addr,  m_addr);
            chk32("mem_wdata", mem_wdata, m_wdata);
            chk1 ("if_ack",    if_ack,    m_ifack);
            chk1 ("dm_ack",    dm_ack,    m_dmack);
            chk32("if_rdata",  if_rdata,  m_ifr);
            chk32("dm_rdata",  dm_rdata,  m_dmr);
            chk1 ("bus_err",   bus_err,   m_err);
            chk1 ("stall_if",  stall_if,  if_req && !m_ifack);
            chk1 ("stall_mem", stall_mem, (dm_readmem || dm_writemem) && !m_dmack);
            model_step();
        end
    end

    // ---------------- directed helpers ----------------
    // Called at posedge+1 of the request cycle; returns at the negedge of the
    // ack cycle with n = cycles from request to ack.
    task automatic wait_first(output bit got_d, output int n);
        n = 0;
        got_d = 0;
        forever begin
            @(negedge clk);
            if (dm_ack === 1'b1 || if_ack === 1'b1) begin
                got_d = dm_ack;
                break;
            end
            n++;
            if (n > 60) begin
                chk1("ack_wait_bound", 1'b0, 1'b1);
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        next_cycle();
        if_req = 0; dm_readmem = 0; dm_writemem = 0;
    endtask

    initial begin : main
        bit gd, gd2;
        int n;
        int k;
        model_reset();
        #2 rst_n = 0;
        repeat (2) @(posedge clk);
        #3;
        chk1 ("rst_mem_req",  mem_req,  1'b0);
        chk1 ("rst_if_ack",   if_ack,   1'b0);
        chk1 ("rst_dm_ack",   dm_ack,   1'b0);
        chk1 ("rst_bus_err",  bus_err,  1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_dm_rdata", dm_rdata, 32'h0);
        next_cycle();
        rst_n = 1;

        // Single fetch, ready on the first mem_req cycle.
        next_cycle();
        delay_knob = 0;
        wmem[32'h40] = 32'h2008_0005;
        if_req = 1; if_addr = 32'h40;
        #2 chk1("fetch_stall_before", stall_if, 1'b1);
        wait_first(gd, n);
        chk32("fetch_latency", n, 2);
        chk1 ("fetch_is_if", gd, 1'b0);
        chk32("fetch_rdata", if_rdata, 32'h2008_0005);
        chk1 ("fetch_stall_ack", stall_if, 1'b0);
        drop_all();

        // Store with three wait cycles.
        next_cycle();
        delay_knob = 3;
        dm_writemem = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
        wait_first(gd, n);
        chk32("store_latency", n, 5);
        chk1 ("store_is_dm", gd, 1'b1);
        chk32("store_rdata_kept", dm_rdata, 32'h0);
        drop_all();

        // Simultaneous requests; data was served last.
        next_cycle();
        delay_knob = 0;
        if_req = 1; if_addr = 32'h80; dm_readmem = 1; dm_addr = 32'h100;
        wait_first(gd, n);
`ifdef MEM_ARB_RR_EN
        chk1("sim_first_fetch", gd, 1'b0);
`else
        chk1("sim_first_data", gd, 1'b1);
`endif
        chk32("sim_first_latency", n, 2);
        next_cycle();
        if (gd) dm_readmem = 0;
        else if_req = 0;
        wait_first(gd2, n);
        chk32("sim_second_gap", n, 1);
        chk1 ("sim_second_other", gd2, !gd);
        chk32("sim_dm_rdata", dm_rdata, 32'h5A5A_0E0F);
        chk32("sim_if_rdata", if_rdata, 32'h5A5A_0F8F);
        drop_all();

        // Both strobes: write wins.
        next_cycle();
        dm_readmem = 1; dm_writemem = 1; dm_addr = 32'h300; dm_wdata = 32'h1234_5678;
        next_cycle();
        chk1 ("both_we", mem_we, 1'b1);
        chk32("both_addr", mem_addr, 32'h300);
        wait_first(gd, n);
        chk32("both_latency", n, 1);
        drop_all();

        // Read back the earlier store.
        next_cycle();
        dm_readmem = 1; dm_addr = 32'h200;
        wait_first(gd, n);
        chk32("readback_store", dm_rdata, 32'hDEAD_BEEF);
        drop_all();

        // Randomized traffic.
        delay_knob = -1;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (if_ack) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = raddr();
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1; if_addr = raddr();
            end
            if (dm_ack || (!dm_readmem && !dm_writemem && $urandom_range(0, 2) == 0)) begin
                k = int'($urandom_range(0, 3));
                dm_readmem  = (k == 0 || k == 2);
                dm_writemem = (k == 1 || k == 2);
                dm_addr     = raddr();
                dm_wdata    = $urandom;
            end
        end
        drop_all();
        repeat (12) next_cycle();

        // Timeout on a read.
        chk1("pre_timeout_err", bus_err, 1'b0);
        delay_knob = 100;
        dm_readmem = 1; dm_addr = 32'h400;
        wait_first(gd, n);
        chk32("timeout_latency", n, MAX_WAIT + 1);
        chk32("timeout_rdata", dm_rdata, 32'h0);
        chk1 ("timeout_err", bus_err, 1'b1);
        drop_all();
        next_cycle();
        delay_knob = 0;
        if_req = 1; if_addr = 32'h40;
        wait_first(gd, n);
        chk32("after_timeout_fetch", if_rdata, 32'h2008_0005);
        chk1 ("err_sticky", bus_err, 1'b1);
        drop_all();

        // Reset while a data read waits.
        next_cycle();
        delay_knob = 100;
        dm_readmem = 1; dm_addr = 32'h500;
        repeat (3) next_cycle();
        #2 rst_n = 0;
        #1;
        chk1("midrst_mem_req", mem_req, 1'b0);
        chk1("midrst_dm_ack", dm_ack, 1'b0);
        chk1("midrst_bus_err", bus_err, 1'b0);
        chk1("midrst_stall_mem", stall_mem, 1'b1);
        delay_knob = 1;
        next_cycle();
        rst_n = 1;
        wait_first(gd, n);
        chk32("after_rst_latency", n, 3);
        chk32("after_rst_rdata", dm_rdata, 32'h5A5A_0A0F);
        drop_all();
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the MEM stage of the 5-stage MIPS pipeline.
- The MEM stage drives the controller's readmem/writemem strobes.
- Arbitrates requests, sequences one memory transaction at a time with a ready handshake, and returns read data.
- Generates the stall signals the hazard logic uses to freeze IF and MEM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_WAIT, 15, cycles allowed for mem_ready before a transaction is aborted (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  instruction fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
dm_readmem  in  1  data read request (controller readmem), held until dm_ack
dm_writemem  in  1  data write request (controller writemem), held until dm_ack
dm_addr  in  ADDR_W  data address (ALU result)
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, valid while dm_ack=1
dm_ack  out  1  one-cycle completion pulse for data access
mem_req  out  1  memory transaction active
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes current transaction this cycle
stall_if  out  1  freeze PC and IF/ID
stall_mem  out  1  freeze EX/MEM and everything upstream
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req, mem_we, if_ack, dm_ack and bus_err = 0; mem_addr, mem_wdata, if_rdata and dm_rdata = 0; wait counter = 0.
  - Reset mid-transaction drops mem_req immediately.
  - No ack is issued for the aborted transaction.
- States: IDLE, GRANT_I, GRANT_D.
- Definitions:
  - dm_pend = (dm_readmem | dm_writemem) & ~dm_ack
  - if_pend = if_req & ~if_ack
- IDLE:
  - dm_pend → GRANT_D. Data has priority; it is the older instruction.
  - Else if_pend → GRANT_I.
  - Else stay in IDLE.
- On grant (registered), latch mem_addr/mem_wdata/mem_we from the granted requester and set mem_req=1.
  - Fetch: mem_we=0.
  - Data: mem_we=dm_writemem. Write wins if both strobes are high.
  - mem_* outputs stay stable until completion.
- GRANT_x with mem_ready=1:
  - Next edge: mem_req=0, the x_ack=1 pulse for exactly 1 cycle, state → IDLE.
  - x_rdata captures mem_rdata on a read. Writes leave dm_rdata unchanged.
  - Minimum latency from request to ack: 2 cycles, with mem_ready high the first cycle of mem_req.
  - Back-to-back transactions have a 1-cycle IDLE gap between them.
- Requesters deassert or change their request in the ack cycle. IDLE ignores a requester whose ack is high that cycle.
- Wait counter:
  - Increments each GRANT cycle with mem_ready=0.
  - On reaching MAX_WAIT: abort, mem_req=0, ack pulse with rdata=0, bus_err=1, state → IDLE.
  - bus_err is sticky until reset.
- stall_if = if_pend (combinational); stall_mem = dm_pend (combinational). Both are 0 in the ack cycle, so the pipeline advances exactly once.
- mem_ready while in IDLE is ignored.
- Request strobes dropping during a grant do not cancel the transaction. It completes and the ack is still pulsed.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin between the two requesters.
  - A last_grant register is reset to I.
  - In IDLE with both pending, grant the requester not served last.
  - With only one pending, grant it.
- Undefined: fixed data priority as above. A continuous data stream can starve fetch; that behaviour is accepted.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ready high 1 cycle after mem_req, mem_rdata=0x2008_0005 → if_ack pulse at cycle 2, if_rdata=0x2008_0005, stall_if=1 until ack.
- Simultaneous: if_req=1 and dm_readmem=1 (dm_addr=0x100) in the same cycle → data served first (mem_we=0, mem_addr=0x100), dm_ack, 1 IDLE gap, then fetch served; with MEM_ARB_RR_EN and last_grant=D, fetch first.
- Store: dm_writemem=1, dm_addr=0x200, dm_wdata=0xDEAD_BEEF, mem_ready after 3 wait cycles → mem_we=1, mem_addr/mem_wdata held stable all 4 cycles, dm_ack 1 cycle, dm_rdata unchanged.
- Both strobes: dm_readmem=dm_writemem=1 → mem_we=1.
- Timeout: MAX_WAIT=15, mem_ready held 0 → after 15 wait cycles mem_req=0, ack with rdata=0, bus_err=1 and it stays 1 through later good transactions.
- Reset mid-op: assert rst_n=0 during GRANT_D wait → mem_req, acks and bus_err = 0 asynchronously (before next edge); after release, IDLE, and a re-presented request completes normally.
